bpc_decomp_arb: RTL

- Round-robin arbiter and sequencer that shares one BPC decompressor instance between NUM_CH requesting channels.
- Grants one compressed block at a time, from input sop through the 16th decompressed output beat.
- While granted, forwards the owner's compressed stream into the decompressor and routes the decompressed beats back to that channel.
- Sits between the channel-side compressed-block queues and the decompressor.

---
 rtl/bpc_decomp_arb.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/bpc_decomp_arb.sv
// Round-robin arbiter sharing one BPC decompressor between NUM_CH channels, one block at a time.
// Optional per-channel completed-block counters on blk_cnt_o: define BPC_DECOMP_ARB_STATS_EN.
module bpc_decomp_arb #(
   parameter int NUM_CH    = 4,
   parameter int CH_W      = 2,
   parameter int OUT_BEATS = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_CH-1:0]      req_valid_i,
   input  logic [NUM_CH*64-1:0]   req_data_i,
   input  logic [NUM_CH-1:0]      req_sop_i,
   input  logic [NUM_CH-1:0]      req_eop_i,
   output logic [NUM_CH-1:0]      req_ready_o,
   output logic                   dec_valid_o,
   output logic [63:0]            dec_data_o,
   output logic                   dec_sop_o,
   output logic                   dec_eop_o,
   input  logic                   dec_ready_i,
   input  logic                   dec_valid_i,
   input  logic [63:0]            dec_data_i,
   input  logic                   dec_sop_i,
   input  logic                   dec_eop_i,
   output logic                   dec_ready_o,
   output logic [NUM_CH-1:0]      rsp_valid_o,
   output logic [63:0]            rsp_data_o,
   output logic                   rsp_sop_o,
   output logic                   rsp_eop_o,
   input  logic [NUM_CH-1:0]      rsp_ready_i,
   output logic                   busy_o,
   output logic [CH_W-1:0]        owner_o,
   output logic                   err_o
`ifdef BPC_DECOMP_ARB_STATS_EN
   ,
   output logic [NUM_CH*16-1:0]   blk_cnt_o
`endif
);

   localparam int CNT_W = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_BEATS - 1);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

   state_t           state, state_nxt;
   logic [CH_W-1:0]  rr_ptr, rr_nxt;
   logic [CH_W-1:0]  owner, owner_nxt;
   logic [CH_W-1:0]  winner, cand;
   logic [CNT_W-1:0] out_cnt, out_cnt_nxt;
   logic             err, err_nxt;
   logic             fed_any, fed_any_nxt;
   logic             found;
   logic             in_xfer, out_xfer, blk_end;
   logic [63:0]      ch_data [NUM_CH];
   int               idx;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         ch_data[c] = req_data_i[c*64 +: 64];
      end
   end

   // First sop-headed channel at or after rr_ptr, wrapping
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      cand   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         cand = CH_W'(idx);
         if (!found && req_valid_i[cand] && req_sop_i[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      owner_nxt   = owner;
      rr_nxt      = rr_ptr;
      out_cnt_nxt = out_cnt;
      err_nxt     = err;
      fed_any_nxt = fed_any;
      req_ready_o = '0;
      dec_valid_o = 1'b0;
      dec_data_o  = '0;
      dec_sop_o   = 1'b0;
      dec_eop_o   = 1'b0;
      dec_ready_o = 1'b0;
      rsp_valid_o = '0;
      rsp_data_o  = '0;
      rsp_sop_o   = 1'b0;
      rsp_eop_o   = 1'b0;
      in_xfer     = 1'b0;
      out_xfer    = 1'b0;
      blk_end     = 1'b0;

      case (state)
         IDLE: begin
            req_ready_o = req_valid_i & ~req_sop_i;
            if (|(req_valid_i & ~req_sop_i)) err_nxt = 1'b1;
            if (found) begin
               owner_nxt   = winner;
               out_cnt_nxt = '0;
               fed_any_nxt = 1'b0;
               state_nxt   = FEED;
            end
         end
         FEED: begin
            dec_valid_o        = req_valid_i[owner];
            dec_data_o         = ch_data[owner];
            dec_sop_o          = req_sop_i[owner];
            dec_eop_o          = req_eop_i[owner];
            req_ready_o[owner] = dec_ready_i;
            in_xfer            = req_valid_i[owner] & dec_ready_i;
            if (in_xfer) begin
               fed_any_nxt = 1'b1;
               if (req_sop_i[owner] && fed_any) err_nxt = 1'b1;
               if (req_eop_i[owner]) state_nxt = DRAIN;
            end
         end
         default: ;
      endcase

      // Decompressed beats route straight back to the owner; the beat count alone ends the block
      if (state != IDLE) begin
         rsp_valid_o[owner] = dec_valid_i;
         rsp_data_o         = dec_data_i;
         rsp_sop_o          = dec_sop_i;
         rsp_eop_o          = dec_eop_i;
         dec_ready_o        = rsp_ready_i[owner];
         out_xfer           = dec_valid_i & rsp_ready_i[owner];
         if (out_xfer) begin
            out_cnt_nxt = out_cnt + 1'b1;
            if (dec_eop_i && (out_cnt != LAST_CNT)) err_nxt = 1'b1;
            if (dec_sop_i && (out_cnt != '0)) err_nxt = 1'b1;
            if (out_cnt == LAST_CNT) begin
               blk_end     = 1'b1;
               state_nxt   = IDLE;
               out_cnt_nxt = '0;
               rr_nxt      = (owner == CH_W'(NUM_CH - 1)) ? '0 : owner + 1'b1;
               if ((state == FEED) && !(in_xfer && req_eop_i[owner])) err_nxt = 1'b1;
            end
         end
      end

      if (rst) req_ready_o = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         owner   <= '0;
         out_cnt <= '0;
         err     <= 1'b0;
         fed_any <= 1'b0;
      end else begin
         state   <= state_nxt;
         rr_ptr  <= rr_nxt;
         owner   <= owner_nxt;
         out_cnt <= out_cnt_nxt;
         err     <= err_nxt;
         fed_any <= fed_any_nxt;
      end
   end

   assign busy_o  = (state != IDLE);
   assign owner_o = owner;
   assign err_o   = err;

`ifdef BPC_DECOMP_ARB_STATS_EN
   logic [15:0] blk_cnt [NUM_CH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) blk_cnt[c] <= '0;
      end else if (blk_end && (blk_cnt[owner] != 16'hFFFF)) begin
         blk_cnt[owner] <= blk_cnt[owner] + 1'b1;
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) blk_cnt_o[c*16 +: 16] = blk_cnt[c];
   end
`endif

endmodule
